rv_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It fetches each instruction over a req/ack instruction-memory handshake and holds it stable for the registered `Decoder`. It then steps the decoded instruction through execute, memory and write-back and owns the program counter. It sits between instruction/data memory and the `Decoder` + ALU + register-file datapath, and is the only block that advances `pc`.

---
 rtl/rv_ctrl_pkg.sv | 37 +++
 rtl/rv_pc_next.sv | 23 ++
 rtl/rv_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_rv_seq_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared state codes, opcode constants and immediate-type codes for the RV32I control sequencer.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_U     = 3'b011;
    localparam logic [2:0] IMM_J     = 3'b100;
    localparam logic [2:0] IMM_R     = 3'b101;
    localparam logic [2:0] IMM_UNDEF = 3'b111;

    // Opcodes that finish through the register-file write-back state.
    function automatic logic is_wb_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_IMM) || (op == OP_LUI) ||
               (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/rv_pc_next.sv
// Next-PC selection: sequential, taken branch, JAL and JALR targets. Arithmetic wraps modulo 2^32.
module rv_pc_next
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] dec_imm,
    input  logic [30:0] alu_hi,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    output logic [31:0] pc_next
);

    always_comb begin
        pc_next = pc + 32'd4;
        case (opcode)
            OP_BRANCH: if (branch_taken) pc_next = pc + dec_imm;
            OP_JAL:    pc_next = pc + dec_imm;
            OP_JALR:   pc_next = {alu_hi, 1'b0};
            default:   ;
        endcase
    end

endmodule

// File: rtl/rv_seq_ctrl.sv
// Multi-cycle RV32I control sequencer: fetch handshake, decode wait, execute/memory/write-back, PC owner.
// Optional handshake watchdog enabled by defining SEQ_TIMEOUT_EN.
//
//   state  | meaning
//   BOOT   | one cycle after reset
//   FETCH  | imem_req high until imem_ack, latch instr
//   DECODE | wait DEC_WAIT cycles for registered decoder
//   EXEC   | dispatch on opcode, branches resolve here
//   MEM    | dmem_req high until dmem_ack
//   WB     | one-cycle rf_we, pc update
//   TRAP   | sticky fault, left only by reset
module rv_seq_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEC_WAIT = 2,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic [6:0]  dec_opcode,
    input  logic [31:0] dec_imm,
    input  logic [2:0]  dec_imm_type,
    input  logic [31:0] alu_result,
    input  logic        branch_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [2:0]  state,
    output logic        trap
);

    localparam logic [2:0] DEC_LOAD = 3'(DEC_WAIT);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [2:0]  dec_cnt;
    logic [31:0] pc_next;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LOAD = 16'(TIMEOUT);
    logic [15:0] to_cnt;
`endif

    rv_pc_next u_pc_next (
        .pc           (pc_q),
        .dec_imm      (dec_imm),
        .alu_hi       (alu_result[31:1]),
        .opcode       (dec_opcode),
        .branch_taken (branch_taken),
        .pc_next      (pc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= PC_RESET;
            instr_q <= '0;
            dec_cnt <= '0;
`ifdef SEQ_TIMEOUT_EN
            to_cnt  <= TO_LOAD;
`endif
        end else begin
`ifdef SEQ_TIMEOUT_EN
            // Counts only while a request is outstanding; any other cycle re-arms it.
            if ((state_q == ST_FETCH && !imem_ack) || (state_q == ST_MEM && !dmem_ack))
                to_cnt <= to_cnt - 16'd1;
            else
                to_cnt <= TO_LOAD;
`endif
            case (state_q)
                ST_BOOT: state_q <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        dec_cnt <= DEC_LOAD;
                        state_q <= ST_DECODE;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (to_cnt == 16'd1) state_q <= ST_TRAP;
`endif
                end
                ST_DECODE: begin
                    if (dec_cnt <= 3'd1) state_q <= ST_EXEC;
                    else                 dec_cnt <= dec_cnt - 3'd1;
                end
                ST_EXEC: begin
                    if (dec_imm_type == IMM_UNDEF) begin
                        state_q <= ST_TRAP;
                    end else if (dec_opcode == OP_LOAD || dec_opcode == OP_STORE) begin
                        state_q <= ST_MEM;
                    end else if (dec_opcode == OP_BRANCH) begin
                        pc_q    <= pc_next;
                        state_q <= ST_FETCH;
                    end else if (is_wb_op(dec_opcode)) begin
                        state_q <= ST_WB;
                    end else begin
                        state_q <= ST_TRAP;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack) begin
                        if (dec_opcode == OP_STORE) begin
                            pc_q    <= pc_next;
                            state_q <= ST_FETCH;
                        end else begin
                            state_q <= ST_WB;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (to_cnt == 16'd1) state_q <= ST_TRAP;
`endif
                end
                ST_WB: begin
                    pc_q    <= pc_next;
                    state_q <= ST_FETCH;
                end
                ST_TRAP: state_q <= ST_TRAP;
                default: state_q <= ST_TRAP;
            endcase
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign dmem_req  = (state_q == ST_MEM);
    assign dmem_we   = (state_q == ST_MEM) && (dec_opcode == OP_STORE);
    assign dmem_addr = alu_result;
    assign rf_we     = (state_q == ST_WB);
    assign pc        = pc_q;
    assign state     = state_q;
    assign trap      = (state_q == ST_TRAP);

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// Bench for rv_seq_ctrl: per-instruction timeline model, per-cycle compare process, literal pins.
module tb_rv_seq_ctrl;

    localparam logic [31:0] PC_RST = 32'h100;
    localparam int          DW     = 2;
    localparam int          TO     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0, instr;
    logic [6:0]  dec_opcode = '0;
    logic [31:0] dec_imm = '0;
    logic [2:0]  dec_imm_type = '0;
    logic [31:0] alu_result = '0;
    logic        branch_taken = 1'b0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0, rf_we, trap;
    logic [31:0] dmem_addr, pc;
    logic [2:0]  state;

    rv_seq_ctrl #(.PC_RESET(PC_RST), .DEC_WAIT(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .dec_opcode(dec_opcode), .dec_imm(dec_imm), .dec_imm_type(dec_imm_type),
        .alu_result(alu_result), .branch_taken(branch_taken), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .pc(pc), .state(state), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic        ireq, dreq, dwe, rfwe, trp;
        logic [31:0] pc, instr, daddr;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        logic [6:0]  op;
        logic [31:0] imm;
        logic [2:0]  it;
        logic [31:0] alu;
        logic        taken;
        int          fwait, mwait;
        logic        stray, pin_en;
        logic [31:0] pin_pc;
    } ins_t;

    exp_t        expq[$];
    int          nchk = 0, nerr = 0;
    logic [31:0] mpc, minstr;
    int          dreq_cyc = 0, rfwe_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (dmem_req === 1'b1) dreq_cyc++;
        if (rf_we === 1'b1)    rfwe_cyc++;
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("state",     {29'd0, state},   {29'd0, e.st});
            chk("imem_req",  {31'd0, imem_req}, {31'd0, e.ireq});
            chk("imem_addr", imem_addr,         e.pc);
            chk("pc",        pc,                e.pc);
            chk("instr",     instr,             e.instr);
            chk("dmem_req",  {31'd0, dmem_req}, {31'd0, e.dreq});
            chk("dmem_we",   {31'd0, dmem_we},  {31'd0, e.dwe});
            chk("rf_we",     {31'd0, rf_we},    {31'd0, e.rfwe});
            chk("trap",      {31'd0, trap},     {31'd0, e.trp});
            if (e.dreq) chk("dmem_addr", dmem_addr, e.daddr);
        end
    end

    function automatic exp_t base();
        exp_t e;
        e = '{st: 3'd0, ireq: 1'b0, dreq: 1'b0, dwe: 1'b0, rfwe: 1'b0, trp: 1'b0,
              pc: mpc, instr: minstr, daddr: 32'd0};
        return e;
    endfunction

    task automatic cyc(input exp_t e, input logic ia, input logic da);
        @(posedge clk);
        #1;
        imem_ack = ia;
        dmem_ack = da;
        expq.push_back(e);
    endtask

    task automatic reset_release();
        exp_t e;
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        mpc = PC_RST;
        minstr = 32'd0;
        e = base();
        expq.push_back(e);
    endtask

    function automatic ins_t mk(input logic [31:0] word, input logic [6:0] op,
                                input logic [31:0] imm, input logic [2:0] it,
                                input logic [31:0] alu, input logic taken,
                                input int fwait, input int mwait, input logic stray,
                                input logic pin_en, input logic [31:0] pin_pc);
        ins_t x;
        x = '{word: word, op: op, imm: imm, it: it, alu: alu, taken: taken,
              fwait: fwait, mwait: mwait, stray: stray, pin_en: pin_en, pin_pc: pin_pc};
        return x;
    endfunction

    // One instruction's whole FETCH..FETCH timeline, derived from its class and handshake delays.
    task automatic run_instr(input ins_t x);
        exp_t e;
        e = base();
        imem_rdata = x.word;
        for (int i = 0; i <= x.fwait; i++) begin
            e.st = 3'd1;
            e.ireq = 1'b1;
            cyc(e, (i == x.fwait), 1'b0);
            if (i == 0) begin
                dec_opcode = x.op;
                dec_imm = x.imm;
                dec_imm_type = x.it;
                alu_result = x.alu;
                branch_taken = x.taken;
                if (x.pin_en) chk("pin_pc", pc, x.pin_pc);
            end
        end
        minstr = x.word;
        e.ireq = 1'b0;
        e.instr = minstr;
        for (int i = 0; i < DW; i++) begin
            e.st = 3'd2;
            cyc(e, x.stray, x.stray);
        end
        e.st = 3'd3;
        cyc(e, 1'b0, 1'b0);
        if (x.it == 3'b111) begin
            e.st = 3'd7;
            e.trp = 1'b1;
            for (int i = 0; i < 8; i++) cyc(e, 1'b0, 1'b0);
            return;
        end
        if (x.op == 7'b1100011) begin
            mpc = x.taken ? mpc + x.imm : mpc + 32'd4;
            return;
        end
        if (x.op == 7'b0000011 || x.op == 7'b0100011) begin
            for (int i = 0; i <= x.mwait; i++) begin
                e.st = 3'd4;
                e.dreq = 1'b1;
                e.dwe = (x.op == 7'b0100011);
                e.daddr = x.alu;
                cyc(e, 1'b0, (i == x.mwait));
            end
            e.dreq = 1'b0;
            e.dwe = 1'b0;
            if (x.op == 7'b0100011) begin
                mpc = mpc + 32'd4;
                return;
            end
        end
        e.st = 3'd5;
        e.rfwe = 1'b1;
        cyc(e, 1'b0, 1'b0);
        if (x.op == 7'b1101111)      mpc = mpc + x.imm;
        else if (x.op == 7'b1100111) mpc = {x.alu[31:1], 1'b0};
        else                         mpc = mpc + 32'd4;
    endtask

    initial begin
        exp_t e;
        int   snap_d, snap_r;
        mpc = PC_RST;
        minstr = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_pc", pc, 32'h100);
        chk("rst_instr", instr, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_reqs", {29'd0, imem_req, dmem_req, rf_we}, 32'd0);
        reset_release();

        snap_r = rfwe_cyc;
        run_instr(mk(32'h002081B3, 7'b0110011, 32'd0, 3'b101, 32'd0, 1'b0, 0, 0, 1'b0, 1'b1, 32'h100));
        run_instr(mk(32'h00208463, 7'b1100011, 32'd8, 3'b010, 32'd0, 1'b1, 0, 0, 1'b0, 1'b1, 32'h104));
        chk("add_beq_rfwe_cycles", rfwe_cyc - snap_r, 32'd1);

        snap_d = dreq_cyc;
        snap_r = rfwe_cyc;
        run_instr(mk(32'h0040A183, 7'b0000011, 32'd4, 3'b000, 32'h2000, 1'b0, 0, 3, 1'b1, 1'b1, 32'h10C));
        run_instr(mk(32'h0030A423, 7'b0100011, 32'd8, 3'b001, 32'h2008, 1'b0, 0, 0, 1'b0, 1'b1, 32'h110));
        run_instr(mk(32'h00208463, 7'b1100011, 32'd8, 3'b010, 32'd0, 1'b0, 2, 0, 1'b0, 1'b1, 32'h114));
        chk("lw_sw_dreq_cycles", dreq_cyc - snap_d, 32'd5);
        chk("lw_sw_rfwe_cycles", rfwe_cyc - snap_r, 32'd1);

        run_instr(mk(32'h00500093, 7'b0010011, 32'd5, 3'b000, 32'd5, 1'b0, 1, 0, 1'b1, 1'b1, 32'h118));
        run_instr(mk(32'h123452B7, 7'b0110111, 32'h12345000, 3'b011, 32'd0, 1'b0, 0, 0, 1'b0, 1'b1, 32'h11C));
        run_instr(mk(32'h000100E7, 7'b1100111, 32'd0, 3'b000, 32'h0000_0203, 1'b0, 0, 0, 1'b0, 1'b1, 32'h120));
        run_instr(mk(32'h000100E7, 7'b1100111, 32'd0, 3'b000, 32'hFFFF_FFFD, 1'b0, 0, 0, 1'b0, 1'b1, 32'h202));
        run_instr(mk(32'h004000EF, 7'b1101111, 32'd4, 3'b100, 32'd0, 1'b0, 0, 0, 1'b0, 1'b1, 32'hFFFF_FFFC));
        run_instr(mk(32'h0000007F, 7'b1111111, 32'd0, 3'b111, 32'd0, 1'b0, 0, 0, 1'b0, 1'b1, 32'h0));
        chk("trap_held", {31'd0, trap}, 32'd1);
        chk("trap_no_fetch", {31'd0, imem_req}, 32'd0);

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("trap_cleared", {31'd0, trap}, 32'd0);
        reset_release();
        e = base();
        e.st = 3'd1;
        e.ireq = 1'b1;
        for (int i = 0; i < 3; i++) cyc(e, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        imem_ack = 1'b1;
        #1;
        chk("midfetch_state", {29'd0, state}, 32'd0);
        chk("midfetch_req", {31'd0, imem_req}, 32'd0);
        chk("midfetch_pc", pc, 32'h100);
        chk("midfetch_instr", instr, 32'd0);
        reset_release();
        run_instr(mk(32'h002081B3, 7'b0110011, 32'd0, 3'b101, 32'd0, 1'b0, 0, 0, 1'b0, 1'b1, 32'h100));

        e = base();
        e.st = 3'd1;
        e.ireq = 1'b1;
`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < TO; i++) cyc(e, 1'b0, 1'b0);
        e.st = 3'd7;
        e.ireq = 1'b0;
        e.trp = 1'b1;
        for (int i = 0; i < 4; i++) cyc(e, 1'b0, 1'b0);
        #1;
        chk("timeout_trap", {29'd0, state}, 32'd7);
`else
        for (int i = 0; i < 100; i++) cyc(e, 1'b0, 1'b0);
        #1;
        chk("no_timeout_fetch", {29'd0, state}, 32'd1);
        chk("no_timeout_req", {31'd0, imem_req}, 32'd1);
`endif
        repeat (2) @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL queue_drain: got %0d required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
